// File: rtl/rot_pkg.sv
// Shared widths and requester ID encodings for the rotate arbiter slice.
package rot_pkg;

  localparam int unsigned ROT_DATA_W = 8;
  localparam int unsigned ROT_AMT_W  = 3;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  typedef logic [ROT_DATA_W-1:0] rot_data_t;
  typedef logic [ROT_AMT_W-1:0]  rot_amt_t;

endpackage

// File: rtl/rotate_arbiter_if.sv
// Request and result handshakes between two producers, the arbiter and one consumer.
interface rotate_arbiter_if;
  import rot_pkg::*;

  logic      req0_valid;
  rot_data_t req0_data;
  rot_amt_t  req0_amt;
  logic      req0_ready;

  logic      req1_valid;
  rot_data_t req1_data;
  rot_amt_t  req1_amt;
  logic      req1_ready;

  logic      out_valid;
  rot_data_t out_data;
  logic      out_id;
  logic      out_ready;

  // Producers and consumer side.
  modport master (
    output req0_valid, req0_data, req0_amt,
    input  req0_ready,
    output req1_valid, req1_data, req1_amt,
    input  req1_ready,
    input  out_valid, out_data, out_id,
    output out_ready
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_data, req0_amt,
    output req0_ready,
    input  req1_valid, req1_data, req1_amt,
    output req1_ready,
    output out_valid, out_data, out_id,
    input  out_ready
  );

endinterface

// File: rtl/barrel_shifter_stage.sv
// Combinational 8-bit rotate-right, three log stages (1, 2, 4 positions).
module barrel_shifter_stage
  import rot_pkg::*;
(
  input  rot_data_t data_i,
  input  rot_amt_t  amt_i,
  output rot_data_t data_o
);

  rot_data_t stage1;
  rot_data_t stage2;

  assign stage1 = amt_i[0] ? {data_i[0],   data_i[ROT_DATA_W-1:1]} : data_i;
  assign stage2 = amt_i[1] ? {stage1[1:0], stage1[ROT_DATA_W-1:2]} : stage1;
  assign data_o = amt_i[2] ? {stage2[3:0], stage2[ROT_DATA_W-1:4]} : stage2;

endmodule

// File: rtl/rotate_arbiter.sv
// Two-requester arbiter sharing one rotate-right datapath, with a registered
// tagged result and saturating per-requester grant counters.
module rotate_arbiter
  import rot_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AMT_W  = 3,
  parameter int unsigned CNT_W  = 16,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  rotate_arbiter_if.slave   bus,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
);

  logic              slot_free;
  logic              gnt0;
  logic              gnt1;
  logic              ready0;
  logic              ready1;
  logic              accept;
  logic              sel_id;
  logic [DATA_W-1:0] op_data;
  logic [AMT_W-1:0]  op_amt;
  rot_data_t         rot_data;

  logic              out_valid_q;
  rot_data_t         out_data_q;
  logic              out_id_q;
  logic              last_grant_q;

  logic [CNT_W-1:0]  gnt_cnt0_d, gnt_cnt0_q;
  logic [CNT_W-1:0]  gnt_cnt1_d, gnt_cnt1_q;

  // Arbitration: a lone requester always wins; contention goes to the
  // requester that did not win last (or to requester 0 in fixed priority).
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt1 = RR_EN ? (last_grant_q == REQ_ID0) : 1'b0;
    end else begin
      gnt1 = bus.req1_valid;
    end
    gnt0    = bus.req0_valid && !gnt1;
    ready0  = gnt0 && slot_free;
    ready1  = gnt1 && slot_free;
    accept  = ready0 || ready1;
    sel_id  = gnt1 ? REQ_ID1 : REQ_ID0;
    op_data = gnt1 ? bus.req1_data : bus.req0_data;
    op_amt  = gnt1 ? bus.req1_amt  : bus.req0_amt;
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  barrel_shifter_stage u_rot (
    .data_i (op_data),
    .amt_i  (op_amt),
    .data_o (rot_data)
  );

  // Result register; an accept in a draining cycle replaces the old result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= REQ_ID0;
      last_grant_q <= REQ_ID1;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= rot_data;
      out_id_q     <= sel_id;
      last_grant_q <= sel_id;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

  // Grant counters saturate; clear beats a same-cycle increment.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (cnt_clr) begin
      gnt_cnt0_d = '0;
      gnt_cnt1_d = '0;
    end else if (accept) begin
      if (sel_id == REQ_ID0) begin
        if (gnt_cnt0_q != '1) gnt_cnt0_d = gnt_cnt0_q + CNT_W'(1);
      end else begin
        if (gnt_cnt1_q != '1) gnt_cnt1_d = gnt_cnt1_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Lock-step bench: a round-robin instance (CNT_W=4) and a fixed-priority instance
// (CNT_W=16) share one stimulus; each is scored against its own reference model.
module tb_rotate_arbiter;
  import rot_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0v, r1v, ordy, clr;
  logic [7:0] r0d, r1d;
  logic [2:0] r0a, r1a;

  always #5 clk = ~clk;

  rotate_arbiter_if ia ();
  rotate_arbiter_if ib ();

  assign ia.req0_valid = r0v;
  assign ia.req0_data  = r0d;
  assign ia.req0_amt   = r0a;
  assign ia.req1_valid = r1v;
  assign ia.req1_data  = r1d;
  assign ia.req1_amt   = r1a;
  assign ia.out_ready  = ordy;
  assign ib.req0_valid = r0v;
  assign ib.req0_data  = r0d;
  assign ib.req0_amt   = r0a;
  assign ib.req1_valid = r1v;
  assign ib.req1_data  = r1d;
  assign ib.req1_amt   = r1a;
  assign ib.out_ready  = ordy;

  logic [3:0]  c0a, c1a;
  logic [15:0] c0b, c1b;

  rotate_arbiter #(.DATA_W(8), .AMT_W(3), .CNT_W(4), .RR_EN(1'b1)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ia.slave),
    .cnt_clr  (clr),
    .gnt_cnt0 (c0a),
    .gnt_cnt1 (c1a)
  );

  rotate_arbiter #(.DATA_W(8), .AMT_W(3), .CNT_W(16), .RR_EN(1'b0)) u_fp (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ib.slave),
    .cnt_clr  (clr),
    .gnt_cnt0 (c0b),
    .gnt_cnt1 (c1b)
  );

  logic [1:0]  o_r0, o_r1, o_v, o_id;
  logic [7:0]  o_d  [2];
  logic [15:0] o_c0 [2];
  logic [15:0] o_c1 [2];

  assign o_r0    = {ib.req0_ready, ia.req0_ready};
  assign o_r1    = {ib.req1_ready, ia.req1_ready};
  assign o_v     = {ib.out_valid,  ia.out_valid};
  assign o_id    = {ib.out_id,     ia.out_id};
  assign o_d[0]  = ia.out_data;
  assign o_d[1]  = ib.out_data;
  assign o_c0[0] = {12'b0, c0a};
  assign o_c1[0] = {12'b0, c1a};
  assign o_c0[1] = c0b;
  assign o_c1[1] = c1b;

  // Reference model state, index 0 = round-robin DUT, 1 = fixed-priority DUT.
  logic       lg  [2];
  logic       mov [2];
  logic [7:0] md  [2];
  logic       mid [2];
  int         mc0 [2];
  int         mc1 [2];
  int         cmax[2] = '{15, 65535};
  logic [8:0] sb0[$];
  logic [8:0] sb1[$];

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input int k, input logic [15:0] obs,
                     input logic [15:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [7:0] ror(input logic [7:0] d, input logic [2:0] a);
    logic [15:0] t;
    t = {d, d} >> a;
    return t[7:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      lg[k] = 1'b1; mov[k] = 1'b0; md[k] = 8'h00; mid[k] = 1'b0;
      mc0[k] = 0;   mc1[k] = 0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_valid"}, k, o_v[k], mov[k]);
      chk({tag, "_data"},  k, o_d[k], md[k]);
      chk({tag, "_id"},    k, o_id[k], mid[k]);
      chk({tag, "_cnt0"},  k, o_c0[k], mc0[k][15:0]);
      chk({tag, "_cnt1"},  k, o_c1[k], mc1[k][15:0]);
    end
  endtask

  task automatic do_reset();
    r0v = 1'b0; r1v = 1'b0; clr = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: check readies against the model, queue expected results,
  // clock, then pop and compare the registered result and counters.
  task automatic cycle();
    logic       en [2];
    logic       g  [2];
    logic       free;
    logic [8:0] e;
    #1;
    for (int k = 0; k < 2; k++) begin
      free = !mov[k] || ordy;
      if (r0v && r1v) g[k] = (k == 0) ? (lg[k] == 1'b0) : 1'b0;
      else            g[k] = r1v;
      en[k] = (r0v || r1v) && free;
      chk("ready0", k, o_r0[k], en[k] && !g[k]);
      chk("ready1", k, o_r1[k], en[k] && g[k]);
      if (en[k]) begin
        e = {g[k], ror(g[k] ? r1d : r0d, g[k] ? r1a : r0a)};
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        mc0[k] = 0; mc1[k] = 0;
      end else if (en[k]) begin
        if (g[k]) begin if (mc1[k] < cmax[k]) mc1[k]++; end
        else      begin if (mc0[k] < cmax[k]) mc0[k]++; end
      end
      if (en[k]) begin
        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
        mov[k] = 1'b1; md[k] = e[7:0]; mid[k] = e[8]; lg[k] = g[k];
      end else if (ordy) begin
        mov[k] = 1'b0;
      end
    end
    check_state("cycle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    ordy = 1'b1; clr = 1'b0;
    r0d = 8'h00; r0a = 3'd0; r1d = 8'h00; r1a = 3'd0;
    do_reset();

    // Single requester, then amt=0 passthrough.
    r0v = 1'b1; r0d = 8'h81; r0a = 3'd1;
    cycle();
    chk("single_data", 0, o_d[0], 8'hC0);
    chk("single_cnt0", 0, o_c0[0], 16'd1);
    r0v = 1'b0;
    cycle();
    r0v = 1'b1; r0d = 8'h5A; r0a = 3'd0;
    cycle();
    chk("amt0_data", 0, o_d[0], 8'h5A);
    r0v = 1'b0;
    cycle();

    // Continuous contention: alternate for RR, requester 0 only for fixed priority.
    do_reset();
    r0v = 1'b1; r0d = 8'hA5; r0a = 3'd3;
    r1v = 1'b1; r1d = 8'h01; r1a = 3'd4;
    repeat (8) cycle();
    chk("rr_cnt0", 0, o_c0[0], 16'd4);
    chk("rr_cnt1", 0, o_c1[0], 16'd4);
    chk("fp_cnt0", 1, o_c0[1], 16'd8);
    chk("fp_cnt1", 1, o_c1[1], 16'd0);

    // Backpressure holds the result and the round-robin pointer.
    do_reset();
    r0v = 1'b1; r1v = 1'b1;
    cycle();
    ordy = 1'b0;
    repeat (5) cycle();
    chk("bp_data", 0, o_d[0], 8'hB4);
    ordy = 1'b1;
    cycle();
    chk("bp_next_id", 0, o_id[0], 1'b1);
    chk("bp_next_data", 0, o_d[0], 8'h10);

    // Counter saturation and clear priority.
    do_reset();
    r0v = 1'b0; r1v = 1'b1; r1d = 8'h3C; r1a = 3'd5;
    repeat (20) cycle();
    chk("sat_cnt1", 0, o_c1[0], 16'd15);
    chk("nosat_cnt1", 1, o_c1[1], 16'd20);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("clr_cnt1", 0, o_c1[0], 16'd0);

    // Asynchronous reset mid-stream with a result pending.
    ordy = 1'b0;
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 0, o_v[0], 1'b0);
    chk("async_valid", 1, o_v[1], 1'b0);
    model_reset();
    r1v = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    r0v = 1'b1; r0d = 8'h0F; r0a = 3'd2;
    r1v = 1'b1; r1d = 8'hF0; r1a = 3'd6;
    cycle();
    chk("post_rst_id", 0, o_id[0], 1'b0);
    r0v = 1'b0; r1v = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
